// File: rtl/frame_pacer_if.sv
// Handshake bundle between the frame pacer and the H.264 decoder control path.
// FRAME_PACER_STEP_EN adds the single-step request line.
interface frame_pacer_if #(
    parameter int OVR_W  = 8,
    parameter int FCNT_W = 16
);
    logic [23:0]       num_cycles_1_frame;
    logic              dec_ready;
    logic              frame_done;
    logic              frame_start;
    logic              playing;
    logic [OVR_W-1:0]  overrun_cnt;
    logic [FCNT_W-1:0] frame_cnt;
`ifdef FRAME_PACER_STEP_EN
    logic              step_req;

    modport master (
        output num_cycles_1_frame, dec_ready, frame_done, step_req,
        input  frame_start, playing, overrun_cnt, frame_cnt
    );

    modport slave (
        input  num_cycles_1_frame, dec_ready, frame_done, step_req,
        output frame_start, playing, overrun_cnt, frame_cnt
    );
`else
    modport master (
        output num_cycles_1_frame, dec_ready, frame_done,
        input  frame_start, playing, overrun_cnt, frame_cnt
    );

    modport slave (
        input  num_cycles_1_frame, dec_ready, frame_done,
        output frame_start, playing, overrun_cnt, frame_cnt
    );
`endif
endinterface

// File: rtl/frame_pacer.sv
// Frame-rate pacer: one frame_start per frame period, honouring decoder ready/done.
// Optional single-step mode from PAUSE is enabled by defining FRAME_PACER_STEP_EN.
module frame_pacer #(
    parameter int OVR_W  = 8,
    parameter int FCNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    frame_pacer_if.slave  bus
);
    localparam logic [1:0] S_PAUSE  = 2'd0;
    localparam logic [1:0] S_START  = 2'd1;
    localparam logic [1:0] S_DECODE = 2'd2;
    localparam logic [1:0] S_WAIT   = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_nextState;
    logic [23:0]       r_periodQ;
    logic [23:0]       r_cnt;
    logic [23:0]       w_lastCnt;
    logic              w_pLive;
    logic              w_hit;
    logic              w_atDeadline;
    logic              w_launch;
    logic              w_overrun;
    logic              w_stepMode;
    logic              w_stepGo;
    logic              r_frameStart;
    logic              r_playing;
    logic [OVR_W-1:0]  r_overrunCnt;
    logic [FCNT_W-1:0] r_frameCnt;

    assign w_pLive      = |bus.num_cycles_1_frame;
    assign w_lastCnt    = (r_periodQ == 24'd0) ? 24'd0 : r_periodQ - 24'd1;
    assign w_atDeadline = (r_cnt >= w_lastCnt);
    // True when the counter sits on, or lands on this edge, the last cycle of the period.
    assign w_hit        = ({1'b0, r_cnt} + 25'd1) >= {1'b0, w_lastCnt};
    assign w_launch     = (r_state == S_START) && bus.dec_ready && (w_pLive || w_stepMode);
    assign w_overrun    = (r_state == S_DECODE) && bus.frame_done && w_atDeadline && !w_stepMode;

`ifdef FRAME_PACER_STEP_EN
    logic r_stepMode;

    assign w_stepMode = r_stepMode;
    assign w_stepGo   = (r_state == S_PAUSE) && bus.step_req && !w_pLive;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stepMode <= 1'b0;
        end else if (w_stepGo) begin
            r_stepMode <= 1'b1;
        end else if (w_nextState == S_PAUSE) begin
            r_stepMode <= 1'b0;
        end
    end
`else
    assign w_stepMode = 1'b0;
    assign w_stepGo   = 1'b0;
`endif

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_PAUSE: begin
                if (w_pLive || w_stepGo) w_nextState = S_START;
            end
            S_START: begin
                if (!w_pLive && !w_stepMode) w_nextState = S_PAUSE;
                else if (bus.dec_ready)      w_nextState = S_DECODE;
            end
            S_DECODE: begin
                // A stepped frame always returns to PAUSE; late or boundary frames relaunch directly.
                if (bus.frame_done) begin
                    if (w_stepMode || !w_pLive) w_nextState = S_PAUSE;
                    else if (w_hit)             w_nextState = S_START;
                    else                        w_nextState = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!w_pLive)   w_nextState = S_PAUSE;
                else if (w_hit) w_nextState = S_START;
            end
            default: w_nextState = S_PAUSE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_PAUSE;
            r_periodQ    <= 24'd0;
            r_cnt        <= 24'd0;
            r_frameStart <= 1'b0;
            r_playing    <= 1'b0;
            r_overrunCnt <= '0;
            r_frameCnt   <= '0;
        end else begin
            r_state      <= w_nextState;
            r_frameStart <= w_launch;
            r_playing    <= (w_nextState != S_PAUSE) && !(w_stepMode || w_stepGo);

            if (w_launch) begin
                r_periodQ  <= bus.num_cycles_1_frame;
                r_cnt      <= 24'd0;
                r_frameCnt <= r_frameCnt + FCNT_W'(1);
            end else if (r_state == S_DECODE || r_state == S_WAIT) begin
                r_cnt <= w_hit ? w_lastCnt : r_cnt + 24'd1;
            end

            if (w_overrun && (r_overrunCnt != {OVR_W{1'b1}})) begin
                r_overrunCnt <= r_overrunCnt + OVR_W'(1);
            end
        end
    end

    assign bus.frame_start = r_frameStart;
    assign bus.playing     = r_playing;
    assign bus.overrun_cnt = r_overrunCnt;
    assign bus.frame_cnt   = r_frameCnt;
endmodule

// File: tb/tb_frame_pacer.sv
// Scoreboard bench for frame_pacer: expected pulses are queued by the stimulus and
// matched by an independent monitor. Covers the step path when FRAME_PACER_STEP_EN is set.
module tb_frame_pacer;
    localparam int OVR_W   = 8;
    localparam int FCNT_W  = 16;
    localparam int OVR_MAX = (1 << OVR_W) - 1;

    typedef struct {
        int cycle;
        int fcnt;
        int ovr;
    } expT;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checkCount = 0;
    int   errorCount = 0;
    int   sExp;
    int   fcntExp;
    int   ovrExp;
    expT  expQ[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    frame_pacer_if #(.OVR_W(OVR_W), .FCNT_W(FCNT_W)) bus ();

    frame_pacer #(.OVR_W(OVR_W), .FCNT_W(FCNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checkCount++;
        if (actual != expected) begin
            errorCount++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    // Monitor: every frame_start must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.frame_start === 1'b1) begin
            if (expQ.size() == 0) begin
                checkCount++;
                errorCount++;
                $display("[TB] FAIL unexpected_pulse at cycle %0d: got frame_start=1, expected 0", cyc);
            end else begin
                expT e;
                e = expQ.pop_front();
                checkOutput("pulse_cycle", cyc, e.cycle);
                checkOutput("pulse_frame_cnt", bus.frame_cnt, e.fcnt);
                checkOutput("pulse_overrun_cnt", bus.overrun_cnt, e.ovr);
            end
        end
    end

    task automatic gotoCycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int p, input logic ready);
        bus.num_cycles_1_frame = p[23:0];
        bus.dec_ready          = ready;
    endtask

    task automatic pushPulse();
        expT e;
        fcntExp   = (fcntExp + 1) % (1 << FCNT_W);
        e.cycle   = sExp;
        e.fcnt    = fcntExp;
        e.ovr     = ovrExp;
        expQ.push_back(e);
    endtask

    // Spacing is max(P, D+2); a frame is late when D+2 exceeds P.
    task automatic playFrames(input int p, input int n, input int d);
        for (int i = 0; i < n; i++) begin
            pushPulse();
            gotoCycle(sExp + d);
            bus.frame_done = 1'b1;
            gotoCycle(sExp + d + 1);
            bus.frame_done = 1'b0;
            if (d + 2 > p) begin
                if (ovrExp < OVR_MAX) ovrExp++;
                sExp = sExp + d + 2;
            end else begin
                sExp = sExp + p;
            end
        end
    endtask

    task automatic checkIdle(input string tag, input int fcnt, input int ovr);
        checkOutput({tag, "_frame_start"}, bus.frame_start, 0);
        checkOutput({tag, "_playing"}, bus.playing, 0);
        checkOutput({tag, "_overrun_cnt"}, bus.overrun_cnt, ovr);
        checkOutput({tag, "_frame_cnt"}, bus.frame_cnt, fcnt);
    endtask

    initial begin
        int u;
        rst_n          = 1'b0;
        bus.frame_done = 1'b0;
        applyStimulus(0, 1'b0);
`ifdef FRAME_PACER_STEP_EN
        bus.step_req = 1'b0;
`endif
        fcntExp = 0;
        ovrExp  = 0;
        repeat (3) @(posedge clk);
        #1;
        checkIdle("reset", 0, 0);
        rst_n = 1'b1;

        gotoCycle(cyc + 200);
        checkIdle("paused_200", 0, 0);

        // On-time frames: P=100, decode 30 cycles
        applyStimulus(100, 1'b1);
        sExp = cyc + 2;
        playFrames(100, 10, 30);
        applyStimulus(0, 1'b1);
        gotoCycle(cyc + 2);
        checkIdle("after_10", 10, 0);

        // Deadline boundary (D=P-2 on time, D=P-1 late), then saturating overruns
        applyStimulus(100, 1'b1);
        sExp = cyc + 2;
        playFrames(100, 1, 98);
        playFrames(100, 1, 99);
        playFrames(100, 258, 150);

        // Pause requested mid-decode: frame completes, no relaunch
        pushPulse();
        gotoCycle(sExp + 10);
        applyStimulus(0, 1'b1);
        gotoCycle(sExp + 30);
        bus.frame_done = 1'b1;
        checkOutput("playing_at_done", bus.playing, 1);
        gotoCycle(sExp + 31);
        bus.frame_done = 1'b0;
        checkOutput("playing_after_done", bus.playing, 0);
        checkOutput("saturated_overrun", bus.overrun_cnt, OVR_MAX);
        checkOutput("frame_cnt_271", bus.frame_cnt, 271);

        // frame_done while paused must be ignored
        gotoCycle(cyc + 5);
        bus.frame_done = 1'b1;
        gotoCycle(cyc + 1);
        bus.frame_done = 1'b0;
        gotoCycle(cyc + 3);
        checkIdle("stray_done", 271, OVR_MAX);

        // Resume at P=50, then stall the next START for 40 cycles
        u = cyc;
        applyStimulus(50, 1'b1);
        sExp = u + 2;
        playFrames(50, 1, 20);
        bus.dec_ready = 1'b0;
        sExp = sExp + 40;
        pushPulse();
        gotoCycle(sExp - 1);
        bus.dec_ready = 1'b1;

        // Asynchronous reset in the middle of DECODE
        gotoCycle(sExp + 10);
        rst_n = 1'b0;
        applyStimulus(0, 1'b1);
        #1;
        checkIdle("async_reset", 0, 0);
        gotoCycle(cyc + 3);
        rst_n   = 1'b1;
        fcntExp = 0;
        ovrExp  = 0;
        gotoCycle(cyc + 20);
        checkIdle("post_reset", 0, 0);

`ifdef FRAME_PACER_STEP_EN
        // Single step from PAUSE: one frame, playing stays low, no overrun
        sExp = cyc + 2;
        pushPulse();
        bus.step_req = 1'b1;
        gotoCycle(cyc + 1);
        bus.step_req = 1'b0;
        gotoCycle(sExp + 5);
        checkOutput("step_playing", bus.playing, 0);
        gotoCycle(sExp + 150);
        bus.frame_done = 1'b1;
        gotoCycle(sExp + 151);
        bus.frame_done = 1'b0;
        gotoCycle(cyc + 30);
        checkIdle("after_step", 1, 0);
`endif

        gotoCycle(cyc + 5);
        checkOutput("pending_pulses", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
